// File: rtl/sad_ex_unit_if.sv
// sad_ex_unit_if: operand/control and result bundle between the ID/EX register and the SAD engine.
// Inputs to the engine: start, small_big, block_idx, valid_in, word_a, word_b, allow_find, clear_min.
// Outputs from the engine: busy, sad_valid, sad_out, min_sad, min_idx, min_updated.
interface sad_ex_unit_if #(
    parameter int ACC_W = 16,
    parameter int IDX_W = 16
);
    logic             start;
    logic             small_big;
    logic [IDX_W-1:0] block_idx;
    logic             valid_in;
    logic [31:0]      word_a;
    logic [31:0]      word_b;
    logic             allow_find;
    logic             clear_min;

    logic             busy;
    logic             sad_valid;
    logic [ACC_W-1:0] sad_out;
    logic [ACC_W-1:0] min_sad;
    logic [IDX_W-1:0] min_idx;
    logic             min_updated;

    // master: pipeline side that issues SAD work
    modport master (
        output start, small_big, block_idx, valid_in, word_a, word_b, allow_find, clear_min,
        input  busy, sad_valid, sad_out, min_sad, min_idx, min_updated
    );

    // slave: the SAD engine itself
    modport slave (
        input  start, small_big, block_idx, valid_in, word_a, word_b, allow_find, clear_min,
        output busy, sad_valid, sad_out, min_sad, min_idx, min_updated
    );
endinterface

// File: rtl/sad_ex_unit.sv
// sad_ex_unit: EX-stage sum-of-absolute-differences engine for 4x4 / 16x16 blocks with running-minimum tracking.
// Ports: clk, rst (async active-high), sadIf (slave modport of sad_ex_unit_if) carrying control, pixel words and results.
// Latency: sad_valid one cycle after the last accepted word; busy high in ACCUM and DONE to stall the front end.
module sad_ex_unit #(
    parameter int ACC_W = 16,
    parameter int IDX_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    sad_ex_unit_if.slave  sadIf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;

    logic [ACC_W-1:0] acc;
    logic [6:0]       count;      // 7 bits so a count of 64 is representable
    logic             bigLat;
    logic             findLat;
    logic [IDX_W-1:0] idxLat;

    logic             sadValid;
    logic [ACC_W-1:0] sadOut;
    logic [ACC_W-1:0] minSad;
    logic [IDX_W-1:0] minIdx;
    logic             minUpdated;

    logic [ACC_W-1:0] wordSad;
    logic [6:0]       countInc;
    logic [6:0]       blockLen;
    logic             acceptWord;
    logic             lastWord;
    logic             startAccept;
    logic             minHit;

    function automatic logic [7:0] absDiff(input logic [7:0] x, input logic [7:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // Byte-wise SAD of one word pair; each lane magnitude is zero-extended before summing.
    always_comb begin
        wordSad = '0;
        for (int lane = 0; lane < 4; lane++) begin
            wordSad = wordSad + ACC_W'(absDiff(sadIf.word_a[lane*8 +: 8], sadIf.word_b[lane*8 +: 8]));
        end
    end

    assign countInc    = count + 7'd1;
    assign blockLen    = bigLat ? 7'd64 : 7'd4;
    assign startAccept = (state == IDLE) && sadIf.start;
    assign acceptWord  = (state == ACCUM) && sadIf.valid_in;
    assign lastWord    = acceptWord && (countInc == blockLen);
    // sadOut already holds the final sum while in DONE, so the compare uses it directly.
    assign minHit      = (state == DONE) && findLat && (sadOut < minSad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (sadIf.start) nextState = ACCUM;
            ACCUM:   if (lastWord) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Block accumulation; valid_in is only honoured in ACCUM, start only in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            count    <= '0;
            bigLat   <= 1'b0;
            findLat  <= 1'b0;
            idxLat   <= '0;
            sadValid <= 1'b0;
            sadOut   <= '0;
        end else begin
            sadValid <= 1'b0;
            if (startAccept) begin
                bigLat  <= sadIf.small_big;
                findLat <= sadIf.allow_find;
                idxLat  <= sadIf.block_idx;
                acc     <= '0;
                count   <= '0;
            end else if (acceptWord) begin
                acc   <= acc + wordSad;
                count <= countInc;
                if (lastWord) begin
                    sadValid <= 1'b1;
                    sadOut   <= acc + wordSad;
                end
            end
        end
    end

    // Minimum tracker; clear_min takes priority over a same-cycle update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            minSad     <= '1;
            minIdx     <= '0;
            minUpdated <= 1'b0;
        end else if (sadIf.clear_min) begin
            minSad     <= '1;
            minIdx     <= '0;
            minUpdated <= 1'b0;
        end else if (minHit) begin
            minSad     <= sadOut;
            minIdx     <= idxLat;
            minUpdated <= 1'b1;
        end else begin
            minUpdated <= 1'b0;
        end
    end

    assign sadIf.busy        = (state != IDLE);
    assign sadIf.sad_valid   = sadValid;
    assign sadIf.sad_out     = sadOut;
    assign sadIf.min_sad     = minSad;
    assign sadIf.min_idx     = minIdx;
    assign sadIf.min_updated = minUpdated;

endmodule

// File: tb/tb_sad_ex_unit.sv
// tb_sad_ex_unit: directed-vector bench for sad_ex_unit with hand-computed expected SAD and minimum values.
// Inputs are driven 1 ns after the rising edge, outputs sampled at the same point (registered state settled).
// Each scenario task checks its own results inline; a single summary line is printed at the end.
module tb_sad_ex_unit;
    localparam int ACC_W = 16;
    localparam int IDX_W = 16;

    logic clk = 1'b0;
    logic rst;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    sad_ex_unit_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) sadIf ();

    sad_ex_unit #(.ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .sadIf (sadIf.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        sadIf.start      = 1'b0;
        sadIf.small_big  = 1'b0;
        sadIf.block_idx  = '0;
        sadIf.valid_in   = 1'b0;
        sadIf.word_a     = '0;
        sadIf.word_b     = '0;
        sadIf.allow_find = 1'b0;
        sadIf.clear_min  = 1'b0;
    endtask

    task automatic begin_block(input logic big, input logic [IDX_W-1:0] idx, input logic find);
        sadIf.start      = 1'b1;
        sadIf.small_big  = big;
        sadIf.block_idx  = idx;
        sadIf.allow_find = find;
        tick();
        sadIf.start      = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] b);
        sadIf.valid_in = 1'b1;
        sadIf.word_a   = a;
        sadIf.word_b   = b;
        tick();
        sadIf.valid_in = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vecs++; if (sadIf.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %0b want 0", sadIf.busy); end
        vecs++; if (sadIf.sad_out !== 16'h0000) begin errs++; $display("FAIL reset_sad_out: got %h want 0000", sadIf.sad_out); end
        vecs++; if (sadIf.min_sad !== 16'hFFFF) begin errs++; $display("FAIL reset_min_sad: got %h want ffff", sadIf.min_sad); end
        vecs++; if (sadIf.min_idx !== 16'h0000) begin errs++; $display("FAIL reset_min_idx: got %h want 0000", sadIf.min_idx); end
        vecs++; if (sadIf.sad_valid !== 1'b0 || sadIf.min_updated !== 1'b0) begin
            errs++; $display("FAIL reset_pulses: got sad_valid=%0b min_updated=%0b want 0/0", sadIf.sad_valid, sadIf.min_updated);
        end
    endtask

    // 4x4 block: each word contributes 0x30+0x10+0x10+0x30 = 0x80, total 0x200.
    // A valid_in coincident with start must be ignored.
    task automatic test_small_block();
        sadIf.valid_in = 1'b1;
        sadIf.word_a   = 32'hFF00_0000;
        sadIf.word_b   = 32'h0000_0000;
        begin_block(1'b0, 16'd5, 1'b1);
        for (int i = 0; i < 3; i++) push_word(32'h1020_3040, 32'h4030_2010);
        vecs++; if (sadIf.sad_valid !== 1'b0 || sadIf.busy !== 1'b1) begin
            errs++; $display("FAIL small_before_last: got sad_valid=%0b busy=%0b want 0/1", sadIf.sad_valid, sadIf.busy);
        end
        push_word(32'h1020_3040, 32'h4030_2010);
        vecs++; if (sadIf.sad_valid !== 1'b1) begin errs++; $display("FAIL small_sad_valid: got %0b want 1", sadIf.sad_valid); end
        vecs++; if (sadIf.sad_out !== 16'h0200) begin errs++; $display("FAIL small_sad_out: got %h want 0200", sadIf.sad_out); end
        tick();
        vecs++; if (sadIf.min_updated !== 1'b1 || sadIf.sad_valid !== 1'b0 || sadIf.busy !== 1'b0) begin
            errs++; $display("FAIL small_after_done: got min_updated=%0b sad_valid=%0b busy=%0b want 1/0/0",
                             sadIf.min_updated, sadIf.sad_valid, sadIf.busy);
        end
        vecs++; if (sadIf.min_sad !== 16'h0200 || sadIf.min_idx !== 16'd5) begin
            errs++; $display("FAIL small_min: got %h/%0d want 0200/5", sadIf.min_sad, sadIf.min_idx);
        end
    endtask

    // 16x16 block of 0xFF differences with bubbles between words: 64 x 4 x 0xFF = 0xFF00.
    task automatic test_big_block_bubbles();
        int early = 0;
        begin_block(1'b1, 16'd11, 1'b1);
        for (int k = 0; k < 64; k++) begin
            push_word(32'hFFFF_FFFF, 32'h0000_0000);
            if (k < 63) begin
                if (sadIf.sad_valid !== 1'b0) early++;
                tick();
                if (sadIf.sad_valid !== 1'b0) early++;
            end
        end
        vecs++; if (early !== 0) begin errs++; $display("FAIL big_early_valid: got %0d early pulses want 0", early); end
        vecs++; if (sadIf.sad_valid !== 1'b1 || sadIf.sad_out !== 16'hFF00) begin
            errs++; $display("FAIL big_sad_out: got valid=%0b sad=%h want 1/ff00", sadIf.sad_valid, sadIf.sad_out);
        end
        tick();
        vecs++; if (sadIf.min_updated !== 1'b0 || sadIf.min_sad !== 16'h0200 || sadIf.min_idx !== 16'd5) begin
            errs++; $display("FAIL big_min_kept: got upd=%0b min=%h idx=%0d want 0/0200/5",
                             sadIf.min_updated, sadIf.min_sad, sadIf.min_idx);
        end
    endtask

    // Equal SAD with a later index must not replace the minimum.
    task automatic test_tie();
        begin_block(1'b0, 16'd9, 1'b1);
        for (int i = 0; i < 4; i++) push_word(32'h1020_3040, 32'h4030_2010);
        vecs++; if (sadIf.sad_out !== 16'h0200) begin errs++; $display("FAIL tie_sad_out: got %h want 0200", sadIf.sad_out); end
        tick();
        vecs++; if (sadIf.min_idx !== 16'd5 || sadIf.min_updated !== 1'b0) begin
            errs++; $display("FAIL tie_min_idx: got idx=%0d upd=%0b want 5/0", sadIf.min_idx, sadIf.min_updated);
        end
    endtask

    // Smaller SAD (0x10, mixed a>b and a<b lanes) but allow_find=0: minimum untouched.
    task automatic test_no_find();
        begin_block(1'b0, 16'd12, 1'b0);
        push_word(32'h0101_0101, 32'h0000_0000);
        push_word(32'h0000_0000, 32'h0101_0101);
        push_word(32'h0100_0100, 32'h0001_0001);
        push_word(32'h8081_7F80, 32'h8180_8081);
        vecs++; if (sadIf.sad_out !== 16'h0010) begin errs++; $display("FAIL nofind_sad_out: got %h want 0010", sadIf.sad_out); end
        tick();
        vecs++; if (sadIf.min_sad !== 16'h0200 || sadIf.min_idx !== 16'd5 || sadIf.min_updated !== 1'b0) begin
            errs++; $display("FAIL nofind_min: got %h/%0d upd=%0b want 0200/5/0",
                             sadIf.min_sad, sadIf.min_idx, sadIf.min_updated);
        end
    endtask

    // start held through ACCUM is ignored; clear_min in the DONE cycle beats the update of a 0x0004 result.
    task automatic test_start_held_clear();
        begin_block(1'b0, 16'd7, 1'b1);
        sadIf.start = 1'b1;
        push_word(32'h0000_0001, 32'h0000_0000);
        push_word(32'h0000_0100, 32'h0000_0000);
        push_word(32'h0001_0000, 32'h0000_0000);
        push_word(32'h0100_0000, 32'h0000_0000);
        sadIf.start = 1'b0;
        vecs++; if (sadIf.sad_valid !== 1'b1 || sadIf.sad_out !== 16'h0004) begin
            errs++; $display("FAIL held_sad_out: got valid=%0b sad=%h want 1/0004", sadIf.sad_valid, sadIf.sad_out);
        end
        sadIf.clear_min = 1'b1;
        tick();
        sadIf.clear_min = 1'b0;
        vecs++; if (sadIf.min_sad !== 16'hFFFF || sadIf.min_idx !== 16'd0 || sadIf.min_updated !== 1'b0) begin
            errs++; $display("FAIL clear_min: got %h/%0d upd=%0b want ffff/0/0",
                             sadIf.min_sad, sadIf.min_idx, sadIf.min_updated);
        end
        vecs++; if (sadIf.busy !== 1'b0) begin errs++; $display("FAIL held_not_queued: got busy=%0b want 0", sadIf.busy); end
    endtask

    // Reset after 2 of 4 words aborts the block; the next block starts from zero.
    task automatic test_reset_mid_block();
        int stray = 0;
        begin_block(1'b0, 16'd3, 1'b1);
        push_word(32'h1020_3040, 32'h4030_2010);
        push_word(32'h1020_3040, 32'h4030_2010);
        rst = 1'b1;
        #1;
        vecs++; if (sadIf.busy !== 1'b0 || sadIf.sad_valid !== 1'b0) begin
            errs++; $display("FAIL midrst_state: got busy=%0b sad_valid=%0b want 0/0", sadIf.busy, sadIf.sad_valid);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sadIf.sad_valid !== 1'b0 || sadIf.busy !== 1'b0) stray++;
        end
        vecs++; if (stray !== 0) begin errs++; $display("FAIL midrst_stray: got %0d stray cycles want 0", stray); end
        begin_block(1'b0, 16'd21, 1'b1);
        for (int i = 0; i < 4; i++) push_word(32'h0101_0101, 32'h0000_0000);
        vecs++; if (sadIf.sad_valid !== 1'b1 || sadIf.sad_out !== 16'h0010) begin
            errs++; $display("FAIL midrst_fresh: got valid=%0b sad=%h want 1/0010", sadIf.sad_valid, sadIf.sad_out);
        end
        tick();
        vecs++; if (sadIf.min_sad !== 16'h0010 || sadIf.min_idx !== 16'd21 || sadIf.min_updated !== 1'b1) begin
            errs++; $display("FAIL midrst_min: got %h/%0d upd=%0b want 0010/21/1",
                             sadIf.min_sad, sadIf.min_idx, sadIf.min_updated);
        end
    endtask

    initial begin
        test_reset();
        test_small_block();
        test_big_block_bubbles();
        test_tie();
        test_no_find();
        test_start_held_clear();
        test_reset_mid_block();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
